// File: rtl/ysyx_22050243_pipe_pkg.sv
// Shared pipeline constants for the EX-stage forwarding/hazard logic.
package ysyx_22050243_pipe_pkg;

  localparam int GPR_ADDR_WIDTH  = 5;

  // Forward select encoding: 0 reads the register file, k+1 bypasses stage k.
  localparam int FWD_SEL_REGFILE = 0;

  // Bypass stage indices, youngest first.
  localparam int STG_EX_MEM      = 0;
  localparam int STG_MEM_WB      = 1;

  // Width of a forward select for a given number of bypass stages.
  function automatic int sel_width(input int num_stages);
    return $clog2(num_stages + 1);
  endfunction

endpackage

// File: rtl/ysyx_22050243_reg_scoreboard.sv
// Register busy scoreboard for multi-cycle ops (mul/div). A bit is set when an
// op leaves EX, cleared when its result is written back, and wiped on flush.
// Lookups see a completing op as already done.
module ysyx_22050243_reg_scoreboard #(
  parameter int GPR_ADDR_WIDTH = 5,
  parameter int NUM_SRC        = 2,
  localparam int NREG          = 2 ** GPR_ADDR_WIDTH
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              mc_issue,
  input  logic [GPR_ADDR_WIDTH-1:0]         mc_rd,
  input  logic                              mc_done,
  input  logic [GPR_ADDR_WIDTH-1:0]         mc_done_rd,
  input  logic                              flush,
  input  logic [NUM_SRC*GPR_ADDR_WIDTH-1:0] look_rs,
  output logic [NUM_SRC-1:0]                look_busy
);

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;

  // Next busy state: clear on done, then set on issue so a new op to the same
  // register wins; flush overrides both. x0 is never busy.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    busy_d = busy_q;
    if (mc_done) begin
      busy_d[mc_done_rd] = 1'b0;
    end
    if (mc_issue && (mc_rd != '0)) begin
      busy_d[mc_rd] = 1'b1;
    end
    if (flush) begin
      busy_d = '0;
    end
    busy_d[0] = 1'b0;
  end

  // Busy register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: the busy array is control state, so it is reset explicitly; a stale bit would stall forever.
    if (rst) begin
      busy_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so all flops update from pre-edge values.
      busy_q <= busy_d;
    end
  end

  // Per-source lookup with write-back bypass: a bit clearing this cycle is not busy.
  always_comb begin
    look_busy = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      look_busy[s] = busy_q[look_rs[s*GPR_ADDR_WIDTH +: GPR_ADDR_WIDTH]] &&
                     !(mc_done &&
                       (mc_done_rd == look_rs[s*GPR_ADDR_WIDTH +: GPR_ADDR_WIDTH]));
    end
  end

endmodule

// File: rtl/ysyx_22050243_fwd_hazard.sv
// EX-stage forwarding and hazard unit: per-source bypass select over the
// bypass stages (youngest wins), load-use bubble, and a multi-cycle busy
// scoreboard. Also counts stall cycles for performance monitoring.
module ysyx_22050243_fwd_hazard
  import ysyx_22050243_pipe_pkg::FWD_SEL_REGFILE;
  import ysyx_22050243_pipe_pkg::sel_width;
#(
  parameter int  GPR_ADDR_WIDTH = ysyx_22050243_pipe_pkg::GPR_ADDR_WIDTH,
  parameter int  NUM_SRC        = 2,
  parameter int  NUM_STAGES     = 2,
  parameter int  CNT_W          = 32,
  localparam int SEL_W          = sel_width(NUM_STAGES)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_SRC*GPR_ADDR_WIDTH-1:0]    ex_rs,
  input  logic                                 id_valid,
  input  logic [NUM_SRC*GPR_ADDR_WIDTH-1:0]    id_rs,
  input  logic [NUM_SRC-1:0]                   id_rs_used,
  input  logic [NUM_STAGES*GPR_ADDR_WIDTH-1:0] stg_rd,
  input  logic [NUM_STAGES-1:0]                stg_reg_w,
  input  logic                                 ex_is_load,
  input  logic [GPR_ADDR_WIDTH-1:0]            ex_rd,
  input  logic                                 ex_reg_w,
  input  logic                                 mc_issue,
  input  logic [GPR_ADDR_WIDTH-1:0]            mc_rd,
  input  logic                                 mc_done,
  input  logic [GPR_ADDR_WIDTH-1:0]            mc_done_rd,
  input  logic                                 flush,
  output logic [NUM_SRC*SEL_W-1:0]             fwd_sel,
  output logic                                 stall_id,
  output logic [CNT_W-1:0]                     stall_cnt
);

  localparam int W = GPR_ADDR_WIDTH;

  logic [NUM_STAGES-1:0] stg_hit [NUM_SRC];
  logic [NUM_SRC-1:0]    lu_src;
  logic [NUM_SRC-1:0]    sb_busy;
  logic                  lu_hit;
  logic                  sb_hit;

  for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
    logic [SEL_W-1:0] sel;

    // A stage can bypass only if it writes a non-zero register matching the source.
    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stg
      assign stg_hit[s][k] = stg_reg_w[k] &&
                             (stg_rd[k*W +: W] != '0) &&
                             (stg_rd[k*W +: W] == ex_rs[s*W +: W]);
    end

    // Priority select: scan oldest to youngest so the youngest hit is left standing.
    always_comb begin
      sel = SEL_W'(FWD_SEL_REGFILE);
      for (int k = NUM_STAGES - 1; k >= 0; k--) begin
        if (stg_hit[s][k]) begin
          sel = SEL_W'(k + 1);
        end
      end
    end

    assign fwd_sel[s*SEL_W +: SEL_W] = sel;

    // ID source reads the register the load in EX is about to produce.
    assign lu_src[s] = id_rs_used[s] && (id_rs[s*W +: W] == ex_rd);
  end

  assign lu_hit = ex_is_load && ex_reg_w && (ex_rd != '0) && (|lu_src);
  assign sb_hit = |(id_rs_used & sb_busy);

  ysyx_22050243_reg_scoreboard #(
    .GPR_ADDR_WIDTH (GPR_ADDR_WIDTH),
    .NUM_SRC        (NUM_SRC)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .mc_issue   (mc_issue),
    .mc_rd      (mc_rd),
    .mc_done    (mc_done),
    .mc_done_rd (mc_done_rd),
    .flush      (flush),
    .look_rs    (id_rs),
    .look_busy  (sb_busy)
  );

  // Stall only a valid ID instruction, and never while reset is applied.
  always_comb begin
    stall_id = !rst && id_valid && (lu_hit || sb_hit);
  end

  // Stall cycle counter, wraps naturally at full scale.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (stall_id) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_ysyx_22050243_fwd_hazard.sv
// Self-checking bench for the forwarding/hazard unit: directed scenarios then
// randomized traffic against a behavioural model.
module tb_ysyx_22050243_fwd_hazard;

  localparam int W     = 5;
  localparam int NS    = 2;
  localparam int NSTG  = 2;
  localparam int CW    = 6;
  localparam int CMOD  = 64;

  logic            clk = 1'b0;
  logic            rst;
  logic [NS*W-1:0] ex_rs;
  logic            id_valid;
  logic [NS*W-1:0] id_rs;
  logic [NS-1:0]   id_rs_used;
  logic [NSTG*W-1:0] stg_rd;
  logic [NSTG-1:0] stg_reg_w;
  logic            ex_is_load;
  logic [W-1:0]    ex_rd;
  logic            ex_reg_w;
  logic            mc_issue;
  logic [W-1:0]    mc_rd;
  logic            mc_done;
  logic [W-1:0]    mc_done_rd;
  logic            flush;
  logic [NS*2-1:0] fwd_sel;
  logic            stall_id;
  logic [CW-1:0]   stall_cnt;

  int checks   = 0;
  int failures = 0;

  bit m_busy [32];
  int m_cnt;

  ysyx_22050243_fwd_hazard #(
    .GPR_ADDR_WIDTH (W),
    .NUM_SRC        (NS),
    .NUM_STAGES     (NSTG),
    .CNT_W          (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ex_rs      (ex_rs),
    .id_valid   (id_valid),
    .id_rs      (id_rs),
    .id_rs_used (id_rs_used),
    .stg_rd     (stg_rd),
    .stg_reg_w  (stg_reg_w),
    .ex_is_load (ex_is_load),
    .ex_rd      (ex_rd),
    .ex_reg_w   (ex_reg_w),
    .mc_issue   (mc_issue),
    .mc_rd      (mc_rd),
    .mc_done    (mc_done),
    .mc_done_rd (mc_done_rd),
    .flush      (flush),
    .fwd_sel    (fwd_sel),
    .stall_id   (stall_id),
    .stall_cnt  (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: youngest writing stage whose dest equals the source (x0 never bypasses).
  function automatic int exp_sel(input int s);
    int r;
    r = int'(ex_rs[s*W +: W]);
    for (int k = 0; k < NSTG; k++) begin
      if (stg_reg_w[k] && int'(stg_rd[k*W +: W]) != 0 && int'(stg_rd[k*W +: W]) == r)
        return k + 1;
    end
    return 0;
  endfunction

  function automatic bit exp_stall();
    bit lu, sb;
    int r;
    if (rst || !id_valid) return 1'b0;
    lu = 1'b0;
    sb = 1'b0;
    for (int s = 0; s < NS; s++) begin
      r = int'(id_rs[s*W +: W]);
      if (id_rs_used[s]) begin
        if (ex_is_load && ex_reg_w && ex_rd != 0 && r == int'(ex_rd)) lu = 1'b1;
        if (m_busy[r] && !(mc_done && int'(mc_done_rd) == r)) sb = 1'b1;
      end
    end
    return lu | sb;
  endfunction

  task automatic clear_model_busy();
    for (int r = 0; r < 32; r++) m_busy[r] = 1'b0;
  endtask

  task automatic idle_inputs();
    rst = 1'b0; ex_rs = '0; id_valid = 1'b0; id_rs = '0; id_rs_used = '0;
    stg_rd = '0; stg_reg_w = '0; ex_is_load = 1'b0; ex_rd = '0; ex_reg_w = 1'b0;
    mc_issue = 1'b0; mc_rd = '0; mc_done = 1'b0; mc_done_rd = '0; flush = 1'b0;
  endtask

  // Check outputs against the model for the current inputs, then advance one clock.
  task automatic step(input string tag);
    int e0, e1;
    bit es;
    e0 = exp_sel(0);
    e1 = exp_sel(1);
    es = exp_stall();
    #1;
    check({tag, ".sel0"}, int'(fwd_sel[1:0]), e0);
    check({tag, ".sel1"}, int'(fwd_sel[3:2]), e1);
    check({tag, ".stall"}, int'(stall_id), int'(es));
    check({tag, ".cnt"}, int'(stall_cnt), m_cnt);
    if (rst) begin
      m_cnt = 0;
      clear_model_busy();
    end else begin
      if (es) m_cnt = (m_cnt + 1) % CMOD;
      if (flush) begin
        clear_model_busy();
      end else begin
        if (mc_done) m_busy[mc_done_rd] = 1'b0;
        if (mc_issue && mc_rd != 0) m_busy[mc_rd] = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int c0;
    idle_inputs();
    rst = 1'b1;
    clear_model_busy();
    m_cnt = 0;
    @(posedge clk);
    #1;
    step("reset");
    rst = 1'b0;
    step("idle");

    // Forwarding priority
    ex_rs[0 +: W] = 5'd5; stg_rd = {5'd5, 5'd5}; stg_reg_w = 2'b11;
    #1 check("fwd_young", int'(fwd_sel[1:0]), 1);
    step("fwd_young");
    stg_reg_w = 2'b10;
    #1 check("fwd_old", int'(fwd_sel[1:0]), 2);
    step("fwd_old");
    ex_rs = '0; stg_rd = '0; stg_reg_w = 2'b11;
    #1 check("fwd_x0", int'(fwd_sel[1:0]), 0);
    step("fwd_x0");
    idle_inputs();

    // Load-use
    id_valid = 1'b1; ex_is_load = 1'b1; ex_reg_w = 1'b1; ex_rd = 5'd7;
    id_rs[W +: W] = 5'd7; id_rs_used = 2'b10;
    #1 check("lu_hit", int'(stall_id), 1);
    step("lu_hit");
    id_rs_used = 2'b01;
    #1 check("lu_unused", int'(stall_id), 0);
    step("lu_unused");
    idle_inputs();

    // Multi-cycle op on x9: six stall cycles, done bypass releases the stall
    mc_issue = 1'b1; mc_rd = 5'd9;
    step("mc_issue9");
    mc_issue = 1'b0;
    id_valid = 1'b1; id_rs[0 +: W] = 5'd9; id_rs_used = 2'b01;
    c0 = m_cnt;
    for (int i = 0; i < 6; i++) begin
      #1 check("mc_busy9", int'(stall_id), 1);
      step("mc_busy9");
    end
    mc_done = 1'b1; mc_done_rd = 5'd9;
    #1 check("mc_done_bypass", int'(stall_id), 0);
    step("mc_done_bypass");
    check("mc_cnt6", int'(stall_cnt), (c0 + 6) % CMOD);
    idle_inputs();

    // Issue and done to the same register: stays busy
    mc_issue = 1'b1; mc_rd = 5'd3; mc_done = 1'b1; mc_done_rd = 5'd3;
    step("issue_done3");
    idle_inputs();
    id_valid = 1'b1; id_rs[0 +: W] = 5'd3; id_rs_used = 2'b01;
    #1 check("busy3_kept", int'(stall_id), 1);
    step("busy3_kept");
    idle_inputs();
    mc_done = 1'b1; mc_done_rd = 5'd3;
    step("done3");
    idle_inputs();

    // Flush after issue, and flush racing an issue
    mc_issue = 1'b1; mc_rd = 5'd4;
    step("issue4");
    idle_inputs();
    flush = 1'b1;
    step("flush");
    flush = 1'b0;
    id_valid = 1'b1; id_rs[0 +: W] = 5'd4; id_rs_used = 2'b01;
    #1 check("flush_clr", int'(stall_id), 0);
    step("flush_clr");
    idle_inputs();
    flush = 1'b1; mc_issue = 1'b1; mc_rd = 5'd4;
    step("flush_vs_issue");
    idle_inputs();
    id_valid = 1'b1; id_rs[W +: W] = 5'd4; id_rs_used = 2'b10;
    #1 check("flush_dom", int'(stall_id), 0);
    step("flush_dom");
    idle_inputs();

    // Reset in the middle of a stall
    mc_issue = 1'b1; mc_rd = 5'd9;
    step("issue9b");
    mc_issue = 1'b0;
    id_valid = 1'b1; id_rs[0 +: W] = 5'd9; id_rs_used = 2'b01;
    step("stall9b");
    rst = 1'b1;
    #1 check("rst_cycle_stall", int'(stall_id), 0);
    step("rst_mid");
    rst = 1'b0;
    #1 check("post_rst_stall", int'(stall_id), 0);
    check("post_rst_cnt", int'(stall_cnt), 0);
    step("post_rst");

    // Counter wrap at 2**CNT_W-1
    idle_inputs();
    mc_issue = 1'b1; mc_rd = 5'd9;
    step("issue9c");
    mc_issue = 1'b0;
    id_valid = 1'b1; id_rs[0 +: W] = 5'd9; id_rs_used = 2'b01;
    for (int i = 0; i < CMOD - 1; i++) step("wrap_fill");
    check("cnt_max", int'(stall_cnt), CMOD - 1);
    step("wrap_last");
    check("cnt_wrap", int'(stall_cnt), 0);
    idle_inputs();
    rst = 1'b1;
    step("rst_pre_rand");

    // Randomized traffic with a small register range to force collisions
    for (int i = 0; i < 400; i++) begin
      rst        = ($urandom_range(0, 39) == 0);
      flush      = ($urandom_range(0, 19) == 0);
      id_valid   = 1'($urandom_range(0, 3) != 0);
      id_rs_used = 2'($urandom);
      for (int s = 0; s < NS; s++) begin
        id_rs[s*W +: W] = 5'($urandom_range(0, 7));
        ex_rs[s*W +: W] = 5'($urandom_range(0, 7));
      end
      for (int k = 0; k < NSTG; k++) stg_rd[k*W +: W] = 5'($urandom_range(0, 7));
      stg_reg_w  = 2'($urandom);
      ex_is_load = 1'($urandom_range(0, 2) == 0);
      ex_reg_w   = 1'($urandom);
      ex_rd      = 5'($urandom_range(0, 7));
      mc_issue   = 1'($urandom_range(0, 3) == 0);
      mc_rd      = 5'($urandom_range(0, 7));
      mc_done    = 1'($urandom_range(0, 3) == 0);
      mc_done_rd = 5'($urandom_range(0, 7));
      step("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
